// File: rtl/ed2_serial_pkg.sv
// Shared definitions for the ed2 serial frame transmitter and its receiver.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package ed2_serial_pkg;

  // FSM state encoding
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Line level when no frame bit is being sent
  localparam logic IDLE_LVL_DEF = 1'b0;

  // Widest word the parity helper supports
  localparam int W_MAX = 32;

  // Even parity: XOR of all bits, so data plus parity has an even number of ones.
  // Narrower words are zero-extended by the caller, which leaves the result unchanged.
  function automatic logic even_parity(input logic [W_MAX-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/serial_frame_tx_piso_shreg.sv
// W-bit parallel-in serial-out shift register, MSB first, with load and shift enables.
// Latency: load or shift takes effect on the next clock edge; msb_nxt previews the MSB after that edge.
// Backpressure: none; load has priority over shift.
module piso_shreg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] din,
  output logic         msb_nxt
);

  logic [W-1:0] q;

  // Capture a new word or move the register one place toward the MSB
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= din;
    end else if (shift) begin
      q <= {q[W-2:0], 1'b0};
    end
  end

  // MSB as it will be after the coming edge, so the serial line can be registered
  always_comb begin
    if (load) begin
      msb_nxt = din[W-1];
    end else if (shift) begin
      msb_nxt = q[W-2];
    end else begin
      msb_nxt = q[W-1];
    end
  end

endmodule

// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: W-bit word in via start/ready, MSB-first out on registered line x.
// Latency: data[W-1] on x one cycle after accept; done pulses W+1 cycles after accept (W+2 with parity).
// Backpressure: ready is low while a frame is on the line; start is ignored then, never queued.
// Build option: SERIAL_FRAME_TX_PARITY_EN appends an even-parity bit after data[0].
module serial_frame_tx
  import ed2_serial_pkg::*;
#(
  parameter int   W        = 8,
  parameter logic IDLE_LVL = IDLE_LVL_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] data,
  output logic         ready,
  output logic         busy,
  output logic         x,
  output logic         done
);

  localparam int CW = $clog2(W + 1);

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic          load;
  logic          shift;
  logic          sh_msb_nxt;
  logic          x_nxt;

  assign load  = ready & start;
  assign shift = (state == SHIFT);

  piso_shreg #(
    .W (W)
  ) u_shreg (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .shift   (shift),
    .din     (data),
    .msb_nxt (sh_msb_nxt)
  );

`ifdef SERIAL_FRAME_TX_PARITY_EN
  logic par_q;

  // Parity is taken from the word at capture, independent of the shifting copy
  always_ff @(posedge clk) begin
    if (rst) begin
      par_q <= 1'b0;
    end else if (load) begin
      par_q <= even_parity(W_MAX'(data));
    end
  end
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Bits left in the data part of the frame; last data bit is sent while cnt is 1
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CW'(W);
    end else if (shift) begin
      cnt <= cnt - CW'(1);
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) state_nxt = SHIFT;
      end
      SHIFT: begin
        if (cnt == CW'(1)) begin
`ifdef SERIAL_FRAME_TX_PARITY_EN
          state_nxt = PAR;
`else
          state_nxt = DONE;
`endif
        end
      end
`ifdef SERIAL_FRAME_TX_PARITY_EN
      PAR: begin
        state_nxt = DONE;
      end
`endif
      DONE: begin
        state_nxt = start ? SHIFT : IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Handshake/status decode from the current state; line value chosen from the next state
  always_comb begin
    ready = (state == IDLE) || (state == DONE);
    busy  = (state == SHIFT) || (state == PAR);
    done  = (state == DONE);
    x_nxt = IDLE_LVL;
    case (state_nxt)
      SHIFT:   x_nxt = sh_msb_nxt;
`ifdef SERIAL_FRAME_TX_PARITY_EN
      PAR:     x_nxt = par_q;
`endif
      default: x_nxt = IDLE_LVL;
    endcase
  end

  // Registered serial line
  always_ff @(posedge clk) begin
    if (rst) begin
      x <= IDLE_LVL;
    end else begin
      x <= x_nxt;
    end
  end

endmodule
